apb_master_exe_w48: RTL and testbench

// APB requester that drives the 48-wide execution-unit slave and any other APB slave on the same bus.
// - Turns single-beat commands from a local valid/ready port into APB SETUP/ACCESS transfers.
// - Waits for PREADY and returns read data plus error/timeout status as a one-cycle response pulse.
// - Sits between the test/control sequencer and the APB bus.

---
 rtl/apb_master_exe_w48.sv | 141 ++++++++++++++
 tb/tb_apb_master_exe_w48.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_exe_w48.sv
// APB requester: turns single-beat valid/ready commands into SETUP/ACCESS transfers.
// Latency: accept at edge N, zero-wait response after N+2; ready is low for the whole transfer.
module apb_master_exe_w48 #(
  parameter int DATA_WIDTH     = 3,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_PCLK,
  input  logic                  i_PRESETn,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_rsp_timeout,
  output logic [ADDR_WIDTH-1:0] o_PADDR,
  output logic                  o_PSEL,
  output logic                  o_PENABLE,
  output logic                  o_PWRITE,
  output logic [DATA_WIDTH-1:0] o_PWDATA,
  input  logic                  i_PREADY,
  input  logic [DATA_WIDTH-1:0] i_PRDATA,
  input  logic                  i_PSLVERR
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_nxt;
  logic                  r_pwrite, w_pwrite_nxt;
  logic                  r_psel, w_psel_nxt;
  logic                  r_penable, w_penable_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;
  logic                  r_rsp_timeout, w_rsp_timeout_nxt;

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pwrite      <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_paddr       <= w_paddr_nxt;
      r_pwdata      <= w_pwdata_nxt;
      r_pwrite      <= w_pwrite_nxt;
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_paddr_nxt       = r_paddr;
    w_pwdata_nxt      = r_pwdata;
    w_pwrite_nxt      = r_pwrite;
    w_psel_nxt        = r_psel;
    w_penable_nxt     = r_penable;
    w_rsp_valid_nxt   = 1'b0;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    w_rsp_timeout_nxt = r_rsp_timeout;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_paddr_nxt   = i_req_addr;
          w_pwdata_nxt  = i_req_wdata;
          w_pwrite_nxt  = i_req_write;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_state_nxt   = S_SETUP;
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
        w_state_nxt   = S_ACCESS;
      end
      S_ACCESS: begin
        // Completion is checked first so PREADY on the threshold edge is never a timeout.
        if (i_PREADY) begin
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_err_nxt     = i_PSLVERR;
          w_rsp_timeout_nxt = 1'b0;
          w_rsp_rdata_nxt   = r_pwrite ? '0 : i_PRDATA;
          w_state_nxt       = S_IDLE;
        end else begin
          if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
          if ((TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST)) begin
            w_psel_nxt        = 1'b0;
            w_penable_nxt     = 1'b0;
            w_rsp_valid_nxt   = 1'b1;
            w_rsp_err_nxt     = 1'b1;
            w_rsp_timeout_nxt = 1'b1;
            w_rsp_rdata_nxt   = '0;
            w_state_nxt       = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_req_ready   = (r_state == S_IDLE);
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_err     = r_rsp_err;
  assign o_rsp_timeout = r_rsp_timeout;
  assign o_PADDR       = r_paddr;
  assign o_PSEL        = r_psel;
  assign o_PENABLE     = r_penable;
  assign o_PWRITE      = r_pwrite;
  assign o_PWDATA      = r_pwdata;

endmodule

// File: tb/tb_apb_master_exe_w48.sv
// Directed bench for apb_master_exe_w48 with TIMEOUT_CYCLES=4; the slave side is driven by hand.
module tb_apb_master_exe_w48;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [2:0]  req_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [2:0]  rsp_rdata;
  logic [15:0] paddr;
  logic        psel, penable, pwrite;
  logic [2:0]  pwdata;
  logic        pready, pslverr;
  logic [2:0]  prdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_master_exe_w48 #(.DATA_WIDTH(3), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
    .i_PCLK(clk), .i_PRESETn(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_rsp_timeout(rsp_timeout),
    .o_PADDR(paddr), .o_PSEL(psel), .o_PENABLE(penable), .o_PWRITE(pwrite),
    .o_PWDATA(pwdata), .i_PREADY(pready), .i_PRDATA(prdata), .i_PSLVERR(pslverr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic wr, input logic [15:0] addr, input logic [2:0] wd);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    #12;
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_paddr", paddr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    tick;
    check("idle_ready", req_ready, 1);

    // Zero-wait write; PREADY already high during SETUP must be ignored.
    request(1'b1, 16'h0000, 3'b101);
    pready = 1'b1;
    tick;
    req_valid = 1'b0;
    check("wr_setup_psel", psel, 1);
    check("wr_setup_penable", penable, 0);
    check("wr_setup_pwrite", pwrite, 1);
    check("wr_setup_pwdata", pwdata, 3'b101);
    check("wr_setup_ready", req_ready, 0);
    tick;
    check("wr_access_penable", penable, 1);
    check("wr_access_rsp_valid", rsp_valid, 0);
    tick;
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_done_psel", psel, 0);
    check("wr_done_penable", penable, 0);
    check("wr_done_paddr_hold", paddr, 0);
    tick;
    check("wr_rsp_pulse", rsp_valid, 0);

    // Zero-wait read.
    request(1'b0, 16'h0000, 3'b000);
    prdata = 3'b110;
    tick;
    req_valid = 1'b0;
    check("rd_setup_ready", req_ready, 0);
    tick;
    check("rd_access_ready", req_ready, 0);
    tick;
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_rdata", rsp_rdata, 3'b110);
    check("rd_rsp_err", rsp_err, 0);
    check("rd_rsp_timeout", rsp_timeout, 0);
    tick;
    check("rd_rdata_held", rsp_rdata, 3'b110);

    // Read with 3 wait states: PREADY rises on the 4th ACCESS edge (timeout boundary).
    request(1'b0, 16'h0001, 3'b000);
    pready = 1'b0;
    prdata = 3'b011;
    tick;
    req_valid = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("wait_penable", penable, 1);
      check("wait_paddr", paddr, 16'h0001);
      check("wait_pwrite", pwrite, 0);
      check("wait_no_rsp", rsp_valid, 0);
    end
    pready = 1'b1;
    tick;
    check("wait_rsp_valid", rsp_valid, 1);
    check("wait_rsp_rdata", rsp_rdata, 3'b011);
    check("boundary_no_timeout", rsp_timeout, 0);
    check("boundary_err", rsp_err, 0);

    // Timeout: PREADY never rises, abort on the 4th ACCESS edge.
    request(1'b0, 16'h0002, 3'b000);
    pready = 1'b0;
    prdata = 3'b111;
    tick;
    req_valid = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("to_wait_psel", psel, 1);
      check("to_wait_no_rsp", rsp_valid, 0);
    end
    tick;
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_timeout", rsp_timeout, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_psel", psel, 0);
    check("to_penable", penable, 0);
    tick;

    // Write completing with a slave error.
    request(1'b1, 16'h0007, 3'b010);
    pready = 1'b1;
    pslverr = 1'b1;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    check("slverr_rsp_valid", rsp_valid, 1);
    check("slverr_err", rsp_err, 1);
    check("slverr_timeout", rsp_timeout, 0);
    check("slverr_rdata", rsp_rdata, 0);
    pslverr = 1'b0;
    tick;

    // Reset asserted mid-ACCESS.
    request(1'b1, 16'h0004, 3'b110);
    pready = 1'b0;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    #1 rst_n = 1'b0;
    #1;
    check("mrst_psel", psel, 0);
    check("mrst_penable", penable, 0);
    check("mrst_paddr", paddr, 0);
    check("mrst_pwdata", pwdata, 0);
    check("mrst_pwrite", pwrite, 0);
    check("mrst_rsp_valid", rsp_valid, 0);
    check("mrst_rsp_err", rsp_err, 0);
    pready = 1'b1;
    tick;
    check("mrst_hold_rsp_valid", rsp_valid, 0);
    rst_n = 1'b1;
    request(1'b0, 16'h0009, 3'b000);
    prdata = 3'b101;
    tick;
    req_valid = 1'b0;
    check("post_rst_psel", psel, 1);
    check("post_rst_paddr", paddr, 16'h0009);
    tick;
    tick;
    check("post_rst_rsp_valid", rsp_valid, 1);
    check("post_rst_rdata", rsp_rdata, 3'b101);
    tick;

    // Back-to-back with req_valid held high: one idle bus cycle between transfers.
    request(1'b1, 16'h0003, 3'b001);
    pready = 1'b1;
    tick;
    check("b2b_1_psel", psel, 1);
    tick;
    check("b2b_1_penable", penable, 1);
    request(1'b1, 16'h0005, 3'b100);
    tick;
    check("b2b_1_rsp_valid", rsp_valid, 1);
    check("b2b_gap_psel", psel, 0);
    check("b2b_gap_ready", req_ready, 1);
    tick;
    req_valid = 1'b0;
    check("b2b_2_psel", psel, 1);
    check("b2b_2_paddr", paddr, 16'h0005);
    check("b2b_2_pwdata", pwdata, 3'b100);
    check("b2b_2_no_rsp", rsp_valid, 0);
    tick;
    tick;
    check("b2b_2_rsp_valid", rsp_valid, 1);
    check("b2b_2_err", rsp_err, 0);
    tick;
    check("b2b_idle_psel", psel, 0);
    check("b2b_idle_ready", req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
